// File: rtl/score_sequencer.sv
// Turns HIT/MISS judgement pulses into one-per-cycle UP pulses for the score counter chain, with a combo multiplier (enabled by COMBO_MULT_EN).
// UP follows a HIT by one cycle and is decoded from registered state; SCORE_MAX suppresses UP in the same cycle and latches SAT.
module score_sequencer #(
   parameter int PEND_W   = 4,
   parameter int MAX_MULT = 4
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic       HIT,
   input  logic       MISS,
   input  logic       SCORE_MAX,
   output logic       UP,
   output logic [2:0] MULT,
   output logic [1:0] STREAK,
   output logic       BUSY,
   output logic       SAT
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, SATD} state_t;

   localparam int SUM_W = PEND_W + 4;
   localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);
`ifdef COMBO_MULT_EN
   localparam logic [2:0] MULT_CAP = 3'(MAX_MULT);
`endif

   state_t            state;
   logic [PEND_W-1:0] pend;
   logic [2:0]        mult;
   logic [1:0]        streak;
   logic              sat;

   logic              hit_ok;
   logic              miss_ok;
   logic [SUM_W-1:0]  sum;
   logic [PEND_W-1:0] pend_next;
   logic [2:0]        mult_next;
   logic [1:0]        streak_next;

   // MISS dominates a coincident HIT; judgements only count while actively running.
   assign hit_ok  = (state == RUN) && ENABLE && HIT && !MISS;
   assign miss_ok = (state == RUN) && ENABLE && MISS;

   assign UP     = ((state == RUN) || (state == DRAIN)) && (pend != '0) && !SCORE_MAX;
   assign BUSY   = (pend != '0);
   assign MULT   = mult;
   assign STREAK = streak;
   assign SAT    = sat;

   // UP only fires when pend >= 1, so the subtraction never underflows.
   always_comb begin
      sum       = SUM_W'(pend) + (hit_ok ? SUM_W'(mult) : '0) - SUM_W'(UP);
      pend_next = (sum > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : sum[PEND_W-1:0];
   end

   always_comb begin
      mult_next   = mult;
      streak_next = streak;
      if (miss_ok) begin
         mult_next   = 3'd1;
         streak_next = 2'd0;
      end else if (hit_ok) begin
         if (streak != 2'd3) begin
            streak_next = streak + 2'd1;
         end else begin
            streak_next = 2'd0;
`ifdef COMBO_MULT_EN
            if (mult < MULT_CAP) mult_next = mult + 3'd1;
`endif
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state  <= IDLE;
         pend   <= '0;
         mult   <= 3'd1;
         streak <= 2'd0;
         sat    <= 1'b0;
      end else if ((state != IDLE) && SCORE_MAX) begin
         state <= SATD;
         pend  <= '0;
         sat   <= 1'b1;
      end else begin
         mult   <= mult_next;
         streak <= streak_next;
         case (state)
            IDLE: begin
               if (ENABLE) state <= RUN;
            end
            RUN: begin
               pend <= pend_next;
               if (!ENABLE) state <= (pend != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
               pend <= pend_next;
               if (ENABLE)          state <= RUN;
               else if (pend == '0) state <= IDLE;
            end
            SATD: begin
               pend <= '0;
               sat  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/score_sequencer.md
# score_sequencer

Sequences increments into the cascaded 3-bit score counter chain of the Dance Dance Revolution datapath. It turns single-cycle HIT/MISS judgement pulses into a stream of one-cycle UP pulses on the least-significant counter stage. It maintains a combo-based point multiplier and stops issuing pulses when the chain reaches its maximum, so the displayed score never wraps. It sits between the step-judgement logic and the score counter stages.

## Interface
- PEND_W, 4, width of the pending-points accumulator; maximum pending value 2^PEND_W-1
- MAX_MULT, 4, ceiling of the point multiplier (1..7)
- CLOCK  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  game running; low = no new points accepted
- HIT  in  1  one-cycle pulse: step judged a hit
- MISS  in  1  one-cycle pulse: step judged a miss
- SCORE_MAX  in  1  high when every counter stage in the chain holds 111
- UP  out  1  increment to LSB counter stage, at most one per cycle
- MULT  out  3  current multiplier
- STREAK  out  2  consecutive hits since last multiplier step
- BUSY  out  1  pending points not yet issued (PEND != 0)
- SAT  out  1  score saturated; sticky until RESET

## Operation
- States: IDLE, RUN, DRAIN, SATD. Reset → IDLE, PEND=0, MULT=1, STREAK=0, SAT=0, UP=0, BUSY=0.
- IDLE: ENABLE=1 → RUN. HIT/MISS are ignored.
- RUN: ENABLE=0 with PEND!=0 → DRAIN; ENABLE=0 with PEND=0 → IDLE.
- DRAIN: new HIT/MISS are ignored; PEND=0 → IDLE. ENABLE rising during DRAIN → RUN.
- Any state except IDLE: SCORE_MAX=1 → SATD. SATD is terminal until RESET: PEND cleared, UP held 0, SAT=1.
- UP = (state RUN or DRAIN) and PEND!=0 and SCORE_MAX=0. UP is decoded from registered state only.
- HIT in RUN adds the pre-update MULT to PEND. Same cycle: PEND_next = PEND + MULT − UP.
- PEND clamps at 2^PEND_W−1; excess points are discarded.
- Multiplier: HIT with STREAK<3 → STREAK+1. HIT with STREAK=3 → STREAK=0 and MULT=min(MULT+1, MAX_MULT).
- MISS in RUN: STREAK=0, MULT=1, PEND unchanged (already-earned points still issue).
- HIT and MISS in the same cycle: MISS wins and no points are added.
- MULT, STREAK and PEND are unaffected by HIT/MISS outside RUN.

## Timing
- HIT sampled at edge t: PEND updated at edge t. UP is high for MULT consecutive cycles starting in the cycle after edge t, unless further HITs extend the run.
- Throughput is one point per cycle. A HIT every cycle at MULT≥2 grows PEND until it clamps.
- SCORE_MAX high in cycle c: UP=0 in cycle c (combinational suppression), SAT=1 from edge c onward.
- RESET asserted mid-drain: UP=0 from the cycle after the reset edge. All pending points are lost.
- The MULT change from a streak step is visible on the next cycle. The HIT that caused the step earns the old value.

## Configuration
- COMBO_MULT_EN defined: multiplier behaves as described above.
- COMBO_MULT_EN undefined:
  - MULT tied to 1; every HIT adds exactly 1 point.
  - STREAK still counts hits 0..3, wraps to 0, and clears on MISS.
  - MAX_MULT is unused.

## Test plan
- Reset, ENABLE=1, single HIT → UP high exactly 1 cycle, one cycle after the HIT edge; BUSY mirrors it; MULT=1.
- 4 HITs spaced 10 cycles apart, then a 5th HIT → first four yield 1 UP each; MULT=2 after the 4th; 5th yields 2 consecutive UP cycles.
- HIT every cycle for 20 cycles with COMBO_MULT_EN, MAX_MULT=4 → MULT saturates at 4, PEND clamps at 15, UP continuous until PEND drains to 0.
- HIT and MISS in the same cycle with MULT=3 → no UP added, MULT=1, STREAK=0; earlier pending points still issue.
- PEND=5, ENABLE dropped → DRAIN issues 5 UP pulses while HITs are ignored, then IDLE with BUSY=0.
- SCORE_MAX raised while PEND=6 → UP low the same cycle, SAT=1 next cycle, stays in SATD until RESET returns all outputs to reset values.
